// File: rtl/core_tx_pkg.sv
// Shared constants for the host transmit arbiter: FSM state codes,
// requester indices and one-hot grant encodings.
package core_tx_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SEND  = 3'd1;
    localparam logic [2:0] ST_GUARD = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_HOLD  = 3'd4;

    localparam logic [0:0] REQ_RB = 1'b0;
    localparam logic [0:0] REQ_MD = 1'b1;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_RB   = 2'b01;
    localparam logic [1:0] GRANT_MD   = 2'b10;

    // Round-robin pointer value that favours the requester not in 'owner'.
    function automatic logic [0:0] rotate_from(input logic [1:0] owner);
        return owner[REQ_MD] ? REQ_RB : REQ_MD;
    endfunction

endpackage

// File: rtl/tx_rr_pick.sv
// Combinational two-way round-robin pick; one-hot result, zero when idle.
module tx_rr_pick
    import core_tx_pkg::*;
(
    input  logic       rb_valid,
    input  logic       md_valid,
    input  logic [0:0] rr_ptr,
    output logic [1:0] pick
);

    always_comb begin
        pick = GRANT_NONE;
        if (rb_valid && md_valid) begin
            pick = (rr_ptr == REQ_MD) ? GRANT_MD : GRANT_RB;
        end else if (rb_valid) begin
            pick = GRANT_RB;
        end else if (md_valid) begin
            pick = GRANT_MD;
        end
    end

endmodule

// File: rtl/tx_arbiter.sv
// Packet-granular arbiter sharing the host serializer between the capture
// readback stream and the metadata stream, with abort and hold timeout.
module tx_arbiter
    import core_tx_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int HOLD_TIMEOUT = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             rb_valid,
    input  logic [WIDTH-1:0] rb_data,
    input  logic             rb_last,
    output logic             rb_ack,
    input  logic             md_valid,
    input  logic [WIDTH-1:0] md_data,
    input  logic             md_last,
    output logic             md_ack,
    input  logic             abort,
    input  logic             tx_busy,
    output logic             tx_send,
    output logic [WIDTH-1:0] tx_data,
    output logic [1:0]       grant,
    output logic             timeout
);

    localparam int CNT_W = (HOLD_TIMEOUT < 1) ? 1 : $clog2(HOLD_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_TIMEOUT);
    localparam bit TIMEOUT_EN = (HOLD_TIMEOUT != 0);

    logic [2:0]       state;
    logic             last_q;
    logic             abort_q;
    logic [0:0]       rr_ptr;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] hold_inc;
    logic [1:0]       pick;
    logic [WIDTH-1:0] pick_data;
    logic             pick_last;
    logic             owner_md;
    logic             owner_valid;
    logic [WIDTH-1:0] owner_data;
    logic             owner_last;

    tx_rr_pick u_pick (
        .rb_valid (rb_valid),
        .md_valid (md_valid),
        .rr_ptr   (rr_ptr),
        .pick     (pick)
    );

    assign pick_data   = pick[REQ_MD] ? md_data : rb_data;
    assign pick_last   = pick[REQ_MD] ? md_last : rb_last;
    assign owner_md    = grant[REQ_MD];
    assign owner_valid = owner_md ? md_valid : rb_valid;
    assign owner_data  = owner_md ? md_data  : rb_data;
    assign owner_last  = owner_md ? md_last  : rb_last;
    assign hold_inc    = (hold_cnt == '1) ? hold_cnt : hold_cnt + 1'b1;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_IDLE;
            last_q   <= 1'b0;
            abort_q  <= 1'b0;
            rr_ptr   <= REQ_MD;
            hold_cnt <= '0;
            rb_ack   <= 1'b0;
            md_ack   <= 1'b0;
            tx_send  <= 1'b0;
            tx_data  <= '0;
            grant    <= GRANT_NONE;
            timeout  <= 1'b0;
        end else begin
            rb_ack  <= 1'b0;
            md_ack  <= 1'b0;
            tx_send <= 1'b0;
            timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!abort && pick != GRANT_NONE) begin
                        grant    <= pick;
                        tx_data  <= pick_data;
                        last_q   <= pick_last;
                        rb_ack   <= pick[REQ_RB];
                        md_ack   <= pick[REQ_MD];
                        hold_cnt <= '0;
                        state    <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (abort) begin
                        grant <= GRANT_NONE;
                        state <= ST_IDLE;
                    end else if (!tx_busy) begin
                        tx_send <= 1'b1;
                        state   <= ST_GUARD;
                    end
                end
                ST_GUARD: begin
                    if (abort) begin
                        last_q  <= 1'b1;
                        abort_q <= 1'b1;
                        grant   <= GRANT_NONE;
                    end
                    state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    // An abort here lets the in-flight word finish, then exits
                    // without rotating; abort_q remembers an abort seen in GUARD.
                    if (abort) begin
                        last_q  <= 1'b1;
                        abort_q <= 1'b1;
                        grant   <= GRANT_NONE;
                    end
                    if (!tx_busy) begin
                        if (last_q || abort) begin
                            if (!(abort_q || abort)) begin
                                rr_ptr <= rotate_from(grant);
                            end
                            abort_q <= 1'b0;
                            grant   <= GRANT_NONE;
                            state   <= ST_IDLE;
                        end else begin
                            hold_cnt <= '0;
                            state    <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (abort) begin
                        grant <= GRANT_NONE;
                        state <= ST_IDLE;
                    end else if (owner_valid) begin
                        tx_data  <= owner_data;
                        last_q   <= owner_last;
                        rb_ack   <= ~owner_md;
                        md_ack   <= owner_md;
                        hold_cnt <= '0;
                        state    <= ST_SEND;
                    end else begin
                        hold_cnt <= hold_inc;
                        if (TIMEOUT_EN && hold_inc == HOLD_LIM) begin
                            timeout <= 1'b1;
                            rr_ptr  <= rotate_from(grant);
                            grant   <= GRANT_NONE;
                            state   <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    grant <= GRANT_NONE;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_arbiter.sv
// Bench for tx_arbiter: directed scenarios plus randomized traffic, all
// outputs compared every cycle against a packet-level reference model.
module tb_tx_arbiter;

    localparam int HT = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        rb_valid = 1'b0, rb_last = 1'b0, md_valid = 1'b0, md_last = 1'b0;
    logic [31:0] rb_data = '0, md_data = '0;
    logic        abort = 1'b0, tx_busy = 1'b0;
    logic        rb_ack, md_ack, tx_send, timeout;
    logic [31:0] tx_data;
    logic [1:0]  grant;

    tx_arbiter #(.WIDTH(32), .HOLD_TIMEOUT(HT)) dut (
        .clock(clock), .reset(reset),
        .rb_valid(rb_valid), .rb_data(rb_data), .rb_last(rb_last), .rb_ack(rb_ack),
        .md_valid(md_valid), .md_data(md_data), .md_last(md_last), .md_ack(md_ack),
        .abort(abort), .tx_busy(tx_busy), .tx_send(tx_send), .tx_data(tx_data),
        .grant(grant), .timeout(timeout)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    // Reference model: tracks where the current word is in its life
    // (waiting to go out, just handed over, draining, awaiting next word).
    localparam int PH_IDLE = 0, PH_PENDING = 1, PH_HANDED = 2, PH_DRAIN = 3, PH_WAIT = 4;
    int          m_ph = PH_IDLE, m_owner = 0, m_fav = 1, m_wait = 0;
    bit          m_last = 0, m_aborted = 0;
    logic        e_rb_ack = 0, e_md_ack = 0, e_send = 0, e_timeout = 0;
    logic [1:0]  e_grant = 0;
    logic [31:0] e_data = 0;

    task automatic take(input int who);
        m_owner  = who;
        e_grant  = (who == 1) ? 2'b10 : 2'b01;
        e_data   = (who == 1) ? md_data : rb_data;
        m_last   = (who == 1) ? md_last : rb_last;
        e_rb_ack = (who == 0);
        e_md_ack = (who == 1);
        m_wait   = 0;
        m_ph     = PH_PENDING;
    endtask

    task automatic model_step();
        bit owner_valid;
        e_rb_ack = 0; e_md_ack = 0; e_send = 0; e_timeout = 0;
        if (reset) begin
            m_ph = PH_IDLE; e_grant = 0; e_data = 0; m_last = 0;
            m_aborted = 0; m_wait = 0; m_fav = 1; m_owner = 0;
            return;
        end
        owner_valid = (m_owner == 1) ? md_valid : rb_valid;
        case (m_ph)
            PH_IDLE:
                if (!abort && (rb_valid || md_valid))
                    take((rb_valid && md_valid) ? m_fav : (rb_valid ? 0 : 1));
            PH_PENDING:
                if (abort) begin m_ph = PH_IDLE; e_grant = 0; end
                else if (!tx_busy) begin e_send = 1; m_ph = PH_HANDED; end
            PH_HANDED: begin
                if (abort) begin m_last = 1; m_aborted = 1; e_grant = 0; end
                m_ph = PH_DRAIN;
            end
            PH_DRAIN: begin
                if (abort) begin m_last = 1; m_aborted = 1; e_grant = 0; end
                if (!tx_busy) begin
                    if (m_last) begin
                        if (!m_aborted) m_fav = 1 - m_owner;
                        m_aborted = 0; e_grant = 0; m_ph = PH_IDLE;
                    end else begin
                        m_wait = 0; m_ph = PH_WAIT;
                    end
                end
            end
            default:
                if (abort) begin m_ph = PH_IDLE; e_grant = 0; end
                else if (owner_valid) take(m_owner);
                else begin
                    m_wait++;
                    if (HT != 0 && m_wait >= HT) begin
                        e_timeout = 1; e_grant = 0; m_fav = 1 - m_owner; m_ph = PH_IDLE;
                    end
                end
        endcase
    endtask

    logic [31:0] send_log[$];

    initial begin
        forever begin
            @(posedge clock);
            model_step();
            #1;
            chk("rb_ack", rb_ack, e_rb_ack);
            chk("md_ack", md_ack, e_md_ack);
            chk("tx_send", tx_send, e_send);
            chk("timeout", timeout, e_timeout);
            chk("grant", grant, e_grant);
            chk("tx_data", tx_data, e_data);
            if (tx_send === 1'b1) send_log.push_back(tx_data);
        end
    end

    // Requesters: each word is presented after its gap and held until acked.
    typedef struct { logic [31:0] data; logic last; int gap; } word_t;
    word_t rq0[$], rq1[$];

    initial begin
        int gap0 = -1, gap1 = -1;
        bit ack0 = 0, ack1 = 0;
        word_t dummy;
        forever begin
            @(posedge clock); #2;
            if (ack0) begin rb_valid = 0; ack0 = 0; dummy = rq0.pop_front(); gap0 = -1; end
            if (!rb_valid && rq0.size() > 0) begin
                if (gap0 < 0) gap0 = rq0[0].gap;
                if (gap0 == 0) begin rb_valid = 1; rb_data = rq0[0].data; rb_last = rq0[0].last; end
                else gap0--;
            end
            if (rb_valid && e_rb_ack) ack0 = 1;
            if (ack1) begin md_valid = 0; ack1 = 0; dummy = rq1.pop_front(); gap1 = -1; end
            if (!md_valid && rq1.size() > 0) begin
                if (gap1 < 0) gap1 = rq1[0].gap;
                if (gap1 == 0) begin md_valid = 1; md_data = rq1[0].data; md_last = rq1[0].last; end
                else gap1--;
            end
            if (md_valid && e_md_ack) ack1 = 1;
        end
    end

    task automatic finish_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic tick();
        @(posedge clock); #3;
    endtask

    task automatic settle();
        int n = 0;
        while ((rq0.size() > 0 || rq1.size() > 0 || rb_valid || md_valid || m_ph != PH_IDLE) && n < 400) begin
            tick(); n++;
        end
        chk("settle_bound", 32'(n < 400), 1);
    endtask

    task automatic wait_send(input string name);
        int n = 0;
        while (tx_send !== 1'b1 && n < 100) begin tick(); n++; end
        chk(name, 32'(n < 100), 1);
    endtask

    task automatic push_pkt(input int r);
        int len = $urandom_range(1, 4);
        for (int i = 0; i < len; i++) begin
            word_t w;
            w.data = $urandom; w.last = (i == len - 1); w.gap = $urandom_range(0, 6);
            if (r == 0) rq0.push_back(w); else rq1.push_back(w);
        end
    endtask

    initial begin
        #900000;
        failures++;
        $display("FAIL watchdog t=%0t actual=running required=finished", $time);
        finish_run();
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, sends;
        logic [31:0] lock_exp [6];
        lock_exp = '{32'h11, 32'h22, 32'h33, 32'hA0, 32'h44, 32'hA1};

        // Reset pick: both valid right after reset, md is favoured.
        rq1.push_back('{32'hAAAA_0001, 1'b1, 0});
        rq0.push_back('{32'hBBBB_0001, 1'b1, 0});
        tick(); tick();
        reset = 0;
        tick();
        chk("rst_md_ack", md_ack, 1); chk("rst_rb_ack", rb_ack, 0); chk("rst_grant", grant, 2'b10);
        tick();
        chk("rst_send", tx_send, 1); chk("rst_data", tx_data, 32'hAAAA_0001);
        tick(); tick(); tick();
        chk("rst_rb_grant", grant, 2'b01); chk("rst_rb_ack2", rb_ack, 1);
        settle();

        // Packet lock and round robin between packets.
        send_log.delete();
        rq0.push_back('{32'h11, 1'b0, 0}); rq0.push_back('{32'h22, 1'b0, 0});
        rq0.push_back('{32'h33, 1'b1, 0}); rq0.push_back('{32'h44, 1'b1, 0});
        rq1.push_back('{32'hA0, 1'b1, 2}); rq1.push_back('{32'hA1, 1'b1, 0});
        settle();
        chk("lock_count", send_log.size(), 6);
        for (int i = 0; i < 6; i++)
            chk("lock_order", (i < send_log.size()) ? send_log[i] : 32'hDEAD_DEAD, lock_exp[i]);

        // Busy stall in SEND, then GUARD must not release on low busy.
        tx_busy = 1;
        rq1.push_back('{32'hB0, 1'b1, 0});
        n = 0;
        while (md_ack !== 1'b1 && n < 50) begin tick(); n++; end
        chk("stall_ack_bound", 32'(n < 50), 1);
        sends = 0;
        for (int i = 0; i < 10; i++) begin tick(); if (tx_send === 1'b1) sends++; end
        chk("stall_no_send", sends, 0);
        tx_busy = 0;
        tick();
        chk("stall_send", tx_send, 1); chk("stall_data", tx_data, 32'hB0);
        tick();
        chk("guard_hold_grant", grant, 2'b10); chk("guard_single", tx_send, 0);
        settle();

        // Timeout: rb stalls mid-packet, waiting md gets the grant.
        rq0.push_back('{32'hC0, 1'b0, 0}); rq0.push_back('{32'hC1, 1'b1, 12});
        rq1.push_back('{32'hD0, 1'b1, 3});
        wait_send("to_send_bound");
        n = 0;
        while (timeout !== 1'b1 && n < 40) begin tick(); n++; end
        chk("to_latency", n, 6);
        chk("to_grant_off", grant, 2'b00);
        tick();
        chk("to_md_grant", grant, 2'b10); chk("to_md_ack", md_ack, 1);
        settle();

        // Abort in HOLD.
        rq0.push_back('{32'hE0, 1'b0, 0}); rq0.push_back('{32'hE1, 1'b1, 20});
        wait_send("ah_send_bound");
        tick(); tick();
        abort = 1;
        tick();
        abort = 0;
        chk("ah_grant", grant, 2'b00); chk("ah_ack", rb_ack, 0); chk("ah_send", tx_send, 0);
        tick();
        chk("ah_idle_send", tx_send, 0);
        settle();

        // Abort in DRAIN: word completes, rr stays on md.
        rq1.push_back('{32'hF0, 1'b0, 0}); rq1.push_back('{32'hF1, 1'b1, 0});
        rq0.push_back('{32'h5A, 1'b1, 2});
        wait_send("ad_send_bound");
        tx_busy = 1;
        tick();
        abort = 1;
        tick();
        abort = 0; tx_busy = 0;
        chk("ad_grant", grant, 2'b00); chk("ad_ack", md_ack, 0);
        tick();
        chk("ad_no_send", tx_send, 0); chk("ad_idle", grant, 2'b00);
        tick();
        chk("ad_rr_md", grant, 2'b10); chk("ad_md_ack", md_ack, 1);
        settle();

        // Reset during GUARD.
        rq0.push_back('{32'h99, 1'b1, 0});
        wait_send("rg_send_bound");
        reset = 1;
        tick();
        reset = 0;
        chk("rg_send", tx_send, 0); chk("rg_grant", grant, 2'b00);
        chk("rg_data", tx_data, 0); chk("rg_ack", rb_ack, 0); chk("rg_timeout", timeout, 0);
        sends = 0;
        for (int i = 0; i < 10; i++) begin tick(); if (tx_send === 1'b1) sends++; end
        chk("rg_no_resend", sends, 0);

        // Randomized traffic.
        begin
            int busy_hold = 0;
            for (int c = 0; c < 3000; c++) begin
                if (rq0.size() == 0 && $urandom_range(0, 3) == 0) push_pkt(0);
                if (rq1.size() == 0 && $urandom_range(0, 3) == 0) push_pkt(1);
                if (busy_hold > 0) busy_hold--;
                else if ($urandom_range(0, 4) == 0) busy_hold = $urandom_range(1, 6);
                tx_busy = (busy_hold > 0);
                abort = ($urandom_range(0, 39) == 0);
                reset = ($urandom_range(0, 299) == 0);
                tick();
            end
        end
        reset = 0; abort = 0; tx_busy = 0;
        settle();
        finish_run();
        $finish;
    end

endmodule

// File: doc/tx_arbiter.md
# tx_arbiter

Shares the single host transmitter (serial/SPI serializer driven by `outputSend`/`outputBusy`) between two word-stream requesters: the capture readback stream from `controller` and the command-response/metadata stream. It grants whole packets, round-robin between packets, sequences the send/busy handshake, and supports abort and a stuck-packet timeout. It sits between `controller`, the metadata responder and the serializer, all on `clock`.

## Interface
- `WIDTH`, 32, data word width.
- `HOLD_TIMEOUT`, 64, cycles the arbiter waits mid-packet for the next word before force-releasing; 0 disables the timeout.
- `clock` in 1: core clock; single clock domain.
- `reset` in 1: synchronous, active-high.
- `rb_valid` in 1: readback word available; held until acked.
- `rb_data` in WIDTH: readback word; stable while `rb_valid` and not acked.
- `rb_last` in 1: the word is the final word of its packet.
- `rb_ack` out 1: one-cycle pulse; word taken.
- `md_valid`, `md_data`, `md_last`, `md_ack`: same as the `rb_*` ports, for the metadata requester.
- `abort` in 1: flush request, e.g. from the reset command.
- `tx_busy` in 1: serializer busy (`outputBusy`).
- `tx_send` out 1: one-cycle send pulse to the serializer.
- `tx_data` out WIDTH: word to transmit; held from latch until the next latch.
- `grant` out 2: one-hot owner, bit0 = rb, bit1 = md; 00 when idle.
- `timeout` out 1: one-cycle pulse when a packet is force-released.

## Operation
- States: IDLE, SEND, GUARD, DRAIN, HOLD.
- **IDLE**
  - If no requester is valid, stay in IDLE.
  - If exactly one requester is valid, pick it. If both are valid, pick the one `rr_ptr` favours.
  - On pick: `grant` = picked one-hot, `tx_data` = its data, `last_q` = its last, its ack pulses, go to SEND.
- **SEND**: when `tx_busy`=0, `tx_send`=1 for one cycle, go to GUARD. Otherwise wait.
- **GUARD**: one cycle unconditionally; `tx_busy` is ignored here because the serializer raises busy the cycle after sampling `tx_send`. Go to DRAIN.
- **DRAIN**: wait for `tx_busy`=0. Then:
  - If `last_q`=1: `grant`=00, `rr_ptr` points to the other requester, go to IDLE.
  - Else go to HOLD.
- **HOLD**
  - The granted requester is locked; the other requester is ignored.
  - When the granted requester is valid: latch its word, ack it, clear the hold counter, go to SEND.
  - While waiting, the hold counter increments each cycle.
  - If `HOLD_TIMEOUT`≠0 and the counter reaches `HOLD_TIMEOUT`: `timeout` pulses, `grant`=00, `rr_ptr` rotates, go to IDLE.
- **abort**
  - In IDLE, SEND or HOLD: go to IDLE, `grant`=00. Any latched unsent word is discarded, no ack is issued, and `rr_ptr` is unchanged.
  - In GUARD or DRAIN: force `last_q`=1 and `grant`=00, and finish the in-flight word normally. DRAIN's exit to IDLE skips the `rr_ptr` rotation.
  - Abort has priority over a simultaneous ack, so the ack is suppressed.
- The hold counter width is `$clog2(HOLD_TIMEOUT+1)`, minimum 1. It saturates and never wraps.

## Timing
- Reset values: `rb_ack`=0, `md_ack`=0, `tx_send`=0, `tx_data`=0, `grant`=00, `timeout`=0, state=IDLE, `last_q`=0, hold counter 0, `rr_ptr` favours md.
- All outputs are registered.
- First word latency: valid sampled in IDLE at edge t → ack high in cycle t+1 → `tx_send` high in cycle t+2 if `tx_busy`=0.
- Minimum per-word period is 4 cycles plus serializer busy time.
- Requester handshake: the requester may change data or valid at the edge ending its ack cycle. A valid held across that edge is treated as a new word.
- A single-word packet (valid and last together) takes the path IDLE→SEND→GUARD→DRAIN→IDLE.
- `tx_busy` high when entering SEND stalls in SEND; no pulse is lost.
- `reset` mid-packet: all registers return to reset values on the next edge; the word in flight at the serializer is not tracked.

## Structure
- Shared package `core_tx_pkg`: state enumeration, requester index constants `REQ_RB`=0 and `REQ_MD`=1, and the one-hot `grant` encodings.
- One sub-module `tx_rr_pick`: combinational 2-way pick from the valids and `rr_ptr`, giving a one-hot result. The FSM, counter and registers stay in `tx_arbiter`.

## Test plan
- **Reset pick:** md and rb both valid in the first cycle after reset → `md_ack` in cycle 1, `grant`=10, `tx_send` in cycle 2 with `md_data`. After md's last word, rb is granted.
- **Packet lock:** rb sends a 3-word packet (0x11, 0x22, 0x33; last on 0x33) while md is continuously valid → three rb sends with no md interleave, then md is granted, then rr returns to rb.
- **Busy stall:** `tx_busy` held high for 10 cycles while in SEND → `tx_send` fires exactly once, the cycle after busy falls. GUARD ignores a busy still low in its cycle.
- **Timeout:** `HOLD_TIMEOUT`=4, rb drops valid after a non-last word → `timeout` pulses after 4 HOLD cycles, `grant`=00, and a waiting md is granted next.
- **Abort in HOLD and in DRAIN:** abort in HOLD → IDLE next cycle with no ack or send. Abort in DRAIN → current word completes, no further ack, and `rr_ptr` is unchanged.
- **Mid-packet reset:** `reset` pulsed in GUARD → all outputs at reset values next cycle, and no second `tx_send`.
